// File: rtl/sdram_arb_pkg.sv
// Shared encodings for the SDRAM burst arbiter: command types, FSM states, data width.
package sdram_arb_pkg;

    localparam int DATA_W = 16;

    localparam logic [1:0] CMD_WR  = 2'd0;
    localparam logic [1:0] CMD_RD  = 2'd1;
    localparam logic [1:0] CMD_REF = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WR,
        ST_RD,
        ST_REF,
        ST_DONE
    } state_e;

endpackage

// File: rtl/frame_addr_gen.sv
// Linear frame address counter: steps by one burst per advance and wraps back to BASE
// at the end of the frame, pulsing wrap_pulse in the wrapping cycle.
module frame_addr_gen #(
    parameter int unsigned BASE        = 0,
    parameter int unsigned FRAME_WORDS = 307200,
    parameter int unsigned BURST_LEN   = 256,
    parameter int unsigned ADDR_W      = 22
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic              wrap_pulse
);

    localparam int unsigned AW1 = ADDR_W + 1;
    // One extra bit so the end-of-frame compare cannot overflow.
    localparam logic [AW1-1:0] LIMIT = AW1'(BASE + FRAME_WORDS);
    localparam logic [AW1-1:0] STEP  = AW1'(BURST_LEN);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [AW1-1:0]    nxt;

    always_comb begin
        nxt        = {1'b0, addr_q} + STEP;
        addr_d     = addr_q;
        wrap_pulse = 1'b0;
        if (advance) begin
            if (nxt >= LIMIT) begin
                addr_d     = ADDR_W'(BASE);
                wrap_pulse = 1'b1;
            end else begin
                addr_d = nxt[ADDR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) addr_q <= ADDR_W'(BASE);
        else     addr_q <= addr_d;
    end

    assign addr = addr_q;

endmodule

// File: rtl/sdram_burst_arbiter.sv
// Latches FIFO trigger pulses, arbitrates them against refresh, issues one burst command
// at a time and steers engine data strobes into the wfifo/rfifo during the burst.
module sdram_burst_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 22,
    parameter int unsigned BURST_LEN   = 256,
    parameter int unsigned LEN_W       = 9,
    parameter int unsigned FRAME_WORDS = 307200,
    parameter int unsigned WR_BASE     = 0,
    parameter int unsigned RD_BASE     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_trig,
    input  logic              rd_trig,
    input  logic              ref_req,
    output logic              ref_ack,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [1:0]        cmd_type,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_data_req,
    input  logic              rd_data_vld,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              burst_done,
    output logic              wfifo_rd_en,
    output logic              rfifo_wr_en,
    output logic [DATA_W-1:0] rfifo_wr_data,
    output logic              busy,
    output logic              frame_wr_done,
    output logic              frame_rd_done,
    output logic              len_err
);

    localparam logic [LEN_W-1:0] BLEN = LEN_W'(BURST_LEN);

    state_e            state_q, state_d;
    logic              wr_pend_q, wr_pend_d;
    logic              rd_pend_q, rd_pend_d;
    logic [1:0]        cmd_type_q, cmd_type_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [LEN_W-1:0]  cmd_len_q, cmd_len_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic              len_err_q, len_err_d;

    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic              accept, beat_in, beat_room, wr_adv, rd_adv;

    assign accept    = (state_q == ST_CMD) && cmd_ready;
    assign beat_room = (beat_q < BLEN);
    assign beat_in   = ((state_q == ST_WR) && wr_data_req) || ((state_q == ST_RD) && rd_data_vld);

    // Beats beyond a full burst are swallowed so the FIFOs never see more than BURST_LEN words.
    assign wfifo_rd_en   = (state_q == ST_WR) && wr_data_req && beat_room;
    assign rfifo_wr_en   = (state_q == ST_RD) && rd_data_vld && beat_room;
    assign rfifo_wr_data = rfifo_wr_en ? rd_data : '0;

    assign ref_ack   = accept && (cmd_type_q == CMD_REF);
    assign cmd_valid = (state_q == ST_CMD);
    assign busy      = (state_q != ST_IDLE);
    assign cmd_type  = cmd_type_q;
    assign cmd_addr  = cmd_addr_q;
    assign cmd_len   = cmd_len_q;
    assign len_err   = len_err_q;

    assign wr_adv = (state_q == ST_DONE) && (cmd_type_q == CMD_WR);
    assign rd_adv = (state_q == ST_DONE) && (cmd_type_q == CMD_RD);

    // A trigger landing in the same cycle as its command's acceptance stays pending.
    assign wr_pend_d = wr_trig | (wr_pend_q & ~(accept && (cmd_type_q == CMD_WR)));
    assign rd_pend_d = rd_trig | (rd_pend_q & ~(accept && (cmd_type_q == CMD_RD)));

    always_comb begin
        state_d    = state_q;
        cmd_type_d = cmd_type_q;
        cmd_addr_d = cmd_addr_q;
        cmd_len_d  = cmd_len_q;
        beat_d     = beat_q;
        len_err_d  = len_err_q;
        case (state_q)
            ST_IDLE: begin
                if (ref_req) begin
                    cmd_type_d = CMD_REF;
                    cmd_addr_d = '0;
                    cmd_len_d  = '0;
                    state_d    = ST_CMD;
                end else if (wr_pend_q) begin
                    cmd_type_d = CMD_WR;
                    cmd_addr_d = wr_addr;
                    cmd_len_d  = BLEN;
                    state_d    = ST_CMD;
                end else if (rd_pend_q) begin
                    cmd_type_d = CMD_RD;
                    cmd_addr_d = rd_addr;
                    cmd_len_d  = BLEN;
                    state_d    = ST_CMD;
                end
            end
            ST_CMD: begin
                if (cmd_ready) begin
                    beat_d = '0;
                    if (cmd_type_q == CMD_WR)      state_d = ST_WR;
                    else if (cmd_type_q == CMD_RD) state_d = ST_RD;
                    else                           state_d = ST_REF;
                end
            end
            ST_WR, ST_RD: begin
                if (beat_in) begin
                    if (beat_room) beat_d    = beat_q + 1'b1;
                    else           len_err_d = 1'b1;
                end
                if (burst_done) begin
                    if (beat_d != BLEN) len_err_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_REF: begin
                if (burst_done) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_pend_q  <= 1'b0;
            rd_pend_q  <= 1'b0;
            cmd_type_q <= '0;
            cmd_addr_q <= '0;
            cmd_len_q  <= '0;
            beat_q     <= '0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_pend_q  <= wr_pend_d;
            rd_pend_q  <= rd_pend_d;
            cmd_type_q <= cmd_type_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_len_q  <= cmd_len_d;
            beat_q     <= beat_d;
            len_err_q  <= len_err_d;
        end
    end

    frame_addr_gen #(
        .BASE        (WR_BASE),
        .FRAME_WORDS (FRAME_WORDS),
        .BURST_LEN   (BURST_LEN),
        .ADDR_W      (ADDR_W)
    ) u_wr_addr (
        .clk        (clk),
        .rst        (rst),
        .advance    (wr_adv),
        .addr       (wr_addr),
        .wrap_pulse (frame_wr_done)
    );

    frame_addr_gen #(
        .BASE        (RD_BASE),
        .FRAME_WORDS (FRAME_WORDS),
        .BURST_LEN   (BURST_LEN),
        .ADDR_W      (ADDR_W)
    ) u_rd_addr (
        .clk        (clk),
        .rst        (rst),
        .advance    (rd_adv),
        .addr       (rd_addr),
        .wrap_pulse (frame_rd_done)
    );

endmodule

// File: doc/sdram_burst_arbiter.md
Name: sdram_burst_arbiter

Overview:
Responder side of the FIFO trigger handshake. Latches the single-cycle wr_trig/rd_trig pulses raised by the FIFO-level watcher, arbitrates them against the refresh request, and issues one burst command at a time to the SDRAM command engine. During each burst it converts engine data strobes into wfifo read enables and rfifo write enables. It owns independent linear frame address counters for writing and reading, and both counters wrap at the frame size.

Parameters:
ADDR_W, 22, linear word address width (bank+row+col).
BURST_LEN, 256, words per burst; equals FIFO trigger threshold.
LEN_W, 9, width of cmd_len and beat counter; must hold BURST_LEN.
FRAME_WORDS, 307200, words per frame (640x480).
WR_BASE, 0, first write address of the frame buffer.
RD_BASE, 0, first read address of the frame buffer.

Ports:
clk  in  1  system/SDRAM clock, rising edge
rst  in  1  asynchronous, active-high reset
wr_trig  in  1  one-cycle pulse: wfifo holds >= BURST_LEN words
rd_trig  in  1  one-cycle pulse: rfifo has room for BURST_LEN words
ref_req  in  1  refresh request level, held until ref_ack
ref_ack  out  1  one-cycle pulse when refresh command is accepted
cmd_valid  out  1  command request to engine
cmd_ready  in  1  engine accepts command when cmd_valid&cmd_ready
cmd_type  out  2  0=WRITE 1=READ 2=REFRESH
cmd_addr  out  ADDR_W  burst start word address
cmd_len  out  LEN_W  burst length (BURST_LEN; 0 for REFRESH)
wr_data_req  in  1  engine takes one write word this cycle
rd_data_vld  in  1  engine delivers one read word this cycle
rd_data  in  16  read word from engine
burst_done  in  1  one-cycle pulse: engine finished current command
wfifo_rd_en  out  1  wfifo read request
rfifo_wr_en  out  1  rfifo write request
rfifo_wr_data  out  16  rfifo write data
busy  out  1  state != IDLE
frame_wr_done  out  1  pulse when write address wraps
frame_rd_done  out  1  pulse when read address wraps
len_err  out  1  sticky: burst beat count != BURST_LEN

Behaviour:
- Reset: all outputs 0; wr_addr=WR_BASE, rd_addr=RD_BASE; pending flags cleared; state=IDLE. Reset mid-burst aborts immediately with no address advance.
- Pending flags: wr_pend is set on wr_trig and cleared on acceptance of a WRITE command. rd_pend is handled the same way. If a trigger and its clear happen in the same cycle, set wins.
- States: IDLE, CMD, WR, RD, REF, DONE.
- IDLE: priority ref_req > wr_pend > rd_pend. The chosen command is registered and the FSM moves to CMD. cmd_valid rises the cycle after the request is seen.
- CMD: cmd_valid=1. cmd_type, cmd_addr and cmd_len stay stable until cmd_ready. On handshake, go to WR, RD or REF; for REFRESH, pulse ref_ack. The beat counter clears on handshake.
- WR: wfifo_rd_en = wr_data_req (combinational). Each beat increments the counter.
- RD: rfifo_wr_en = rd_data_vld and rfifo_wr_data = rd_data (combinational). Each beat increments the counter.
- Beat overrun: beats after the counter reaches BURST_LEN are not forwarded, and len_err is set.
- Strobes outside WR/RD: ignored; their enables stay 0.
- On burst_done in WR/RD: len_err sets if count != BURST_LEN. The FSM then moves to DONE.
- On burst_done in REF: go to DONE.
- burst_done in any other state: ignored.
- DONE (1 cycle): advance the address of the finished direction by BURST_LEN. If the result is >= base+FRAME_WORDS, load the base and pulse frame_*_done. Then return to IDLE.
- Minimum gap: one IDLE cycle between commands.
- Address arithmetic: ADDR_W unsigned. FRAME_WORDS must be a multiple of BURST_LEN.

Decomposition:
- Package sdram_arb_pkg: cmd_type encodings CMD_WR/CMD_RD/CMD_REF, FSM state enum, data width constant 16.
- Sub-module frame_addr_gen (params BASE, FRAME_WORDS, BURST_LEN, ADDR_W): ports clk, rst, advance, addr, wrap_pulse. Instantiated twice, once for write and once for read.

Test Plan:
- Reset: assert rst mid-WR burst -> all outputs 0 same cycle; after release, next WRITE cmd_addr=0.
- Single write: wr_trig pulse; cmd_ready high 3 cycles after cmd_valid; 256 wr_data_req; burst_done -> 256 wfifo_rd_en, cmd_type=0, cmd_addr=0, cmd_len=256; next write addr=256, len_err=0.
- Priority: ref_req, wr_trig, rd_trig all in the same cycle, cmd_ready tied 1 -> order REFRESH (ref_ack pulse), WRITE@0, READ@0.
- Wrap: FRAME_WORDS=512. Three write bursts -> addrs 0, 256, 0; frame_wr_done pulses once, in DONE of the second burst.
- Length errors: burst_done after 200 wr_data_req -> len_err=1. Separate run with 260 rd_data_vld -> exactly 256 rfifo_wr_en, len_err=1.
- Trigger during burst: rd_trig arrives while in WR -> READ issued right after DONE+IDLE; a second wr_trig at the same cycle as WRITE acceptance -> a second WRITE follows.
